cu_command_arbiter_rr: RTL
==========================

# cu_command_arbiter_rr

Round-robin arbiter that shares the single CAPI command issue path among NUM_REQUESTORS compute-unit command buffers (vertex CUs plus the vertex-control unit). It grants at most one request per cycle and registers the winning command into a one-entry output stage tagged with the winner's CU ID. It gates issue on a credit counter that tracks outstanding commands the PSL will accept. It sits between the per-CU command buffers and the AFU-control command path.

## Interface
- NUM_REQUESTORS, 8, number of requesting CUs (2..16)
- CMD_BITS, 96, width of one command payload (address, size, command code)
- CU_ID_RANGE, 8, width of emitted CU ID
- MAX_CREDITS, 64, credit count at reset and saturation ceiling
- CREDIT_BITS, $clog2(MAX_CREDITS+1), credit counter width
- clock  in  1  sole clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- enabled  in  1  when low, no new grants; the output stage still drains
- req_valid  in  NUM_REQUESTORS  per-requester command pending
- req_payload  in  NUM_REQUESTORS*CMD_BITS  requester i occupies bits [i*CMD_BITS +: CMD_BITS]
- req_ready  out  NUM_REQUESTORS  one-hot grant; requester i pops its buffer when req_valid[i] & req_ready[i]
- cmd_valid  out  1  output stage holds a command
- cmd_payload  out  CMD_BITS  granted payload
- cmd_cu_id  out  CU_ID_RANGE  zero-extended index of granted requester
- cmd_ready  in  1  downstream accepts the output stage this cycle
- credit_return  in  1  one credit returned this cycle
- credits_available  out  CREDIT_BITS  current credit register
- credit_overflow  out  1  sticky; a return arrived while credits == MAX_CREDITS

## Operation
- The slot is free when the stage is empty or when cmd_valid & cmd_ready in this cycle.
- A grant is allowed when the slot is free, enabled is 1, credits_available != 0 (registered value), and at least one req_valid bit is set.
- Selection: search starts at index last_grant+1 and wraps modulo NUM_REQUESTORS. The first set req_valid wins.
- req_ready is combinational. It is the winner's one-hot bit when a grant is allowed, else all zeros. It is never asserted for a requester whose req_valid is 0.
- On a grant to requester i:
  - payload i and cu_id i are registered into the output stage, and cmd_valid = 1 next cycle.
  - last_grant <= i.
  - credits decrement by 1.
- Credit update per cycle: grant & ~credit_return gives -1. ~grant & credit_return gives +1, saturating at MAX_CREDITS. Grant & return together leave credits unchanged.
- A return in the cycle credits reach MAX_CREDITS sets credit_overflow. It stays set until reset.
- Output stage: cmd_payload and cmd_cu_id are stable while cmd_valid & ~cmd_ready. On cmd_ready with no new grant, cmd_valid <= 0, and payload and cu_id hold their last value.
- A mid-operation drop of enabled leaves a held command valid until it is accepted. Credits keep updating.
- A requester that deasserts req_valid without being granted loses nothing. The search pointer does not move.

## Timing
- Reset values: cmd_valid 0, cmd_payload 0, cmd_cu_id 0, credits_available MAX_CREDITS, credit_overflow 0. last_grant = NUM_REQUESTORS-1, so index 0 has first priority. req_ready is 0 while rstn is low.
- Reset asserted mid-operation discards any held command immediately (asynchronous). No command is emitted after reset releases until a new grant.
- Latency: a grant in cycle T gives cmd_valid in T+1.
- Throughput: one command per cycle while cmd_ready is held high and credits are available.
- Backpressure: with cmd_ready low and cmd_valid high, there are no grants and req_ready is 0.
- Credits = 0: no grant. A credit_return in the same cycle allows a grant in the following cycle, not the same one.

## Test plan
- Fairness: all 8 req_valid held high, cmd_ready=1, credits=64 -> cmd_cu_id sequence 0,1,...,7,0 on consecutive cycles. req_ready one-hot each cycle.
- Sparse: only requesters 2 and 5 valid, last_grant=5 -> grants 2,5,2,5. An index that drops req_valid before its turn is skipped with no bubble.
- Backpressure: cmd_ready=0 for 4 cycles holding payload 0xABC from CU 3 -> cmd_payload/cmd_cu_id stable and req_ready=0 for those cycles. Grant resumes in the cycle cmd_ready rises.
- Credit exhaustion: MAX_CREDITS=4, no returns, continuous requests -> exactly 4 commands, then credits_available=0 and no grants. One credit_return pulse -> exactly one more grant, in the following cycle.
- Credit edge: grant and credit_return in the same cycle at credits=10 -> stays 10. Return at credits=MAX_CREDITS -> stays MAX and credit_overflow=1 permanently.
- Reset: rstn pulsed low while cmd_valid=1 and credits=20 -> outputs cleared asynchronously and credits=64. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/cu_command_arbiter_rr.sv
// Round-robin arbiter sharing one CAPI command issue path among the CU command buffers.
// The winner is registered into a one-entry output stage; issue is gated by a PSL credit counter.
module cu_command_arbiter_rr #(
    parameter int NUM_REQUESTORS = 8,
    parameter int CMD_BITS       = 96,
    parameter int CU_ID_RANGE    = 8,
    parameter int MAX_CREDITS    = 64,
    parameter int CREDIT_BITS    = $clog2(MAX_CREDITS + 1)
) (
    input  logic                               clock,
    input  logic                               rstn,
    input  logic                               enabled,
    input  logic [NUM_REQUESTORS-1:0]          req_valid,
    input  logic [NUM_REQUESTORS*CMD_BITS-1:0] req_payload,
    output logic [NUM_REQUESTORS-1:0]          req_ready,
    output logic                               cmd_valid,
    output logic [CMD_BITS-1:0]                cmd_payload,
    output logic [CU_ID_RANGE-1:0]             cmd_cu_id,
    input  logic                               cmd_ready,
    input  logic                               credit_return,
    output logic [CREDIT_BITS-1:0]             credits_available,
    output logic                               credit_overflow
);

    localparam int                      IDX_W      = $clog2(NUM_REQUESTORS);
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_REQUESTORS - 1);
    localparam logic [CREDIT_BITS-1:0]  CREDIT_MAX = CREDIT_BITS'(MAX_CREDITS);

    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [CMD_BITS-1:0]    cmd_payload_q, cmd_payload_d;
    logic [CU_ID_RANGE-1:0] cmd_cu_id_q, cmd_cu_id_d;
    logic [CREDIT_BITS-1:0] credits_q, credits_d;
    logic                   overflow_q, overflow_d;

    logic                   winner_found;
    logic [IDX_W-1:0]       winner_idx;
    logic [IDX_W-1:0]       cand_idx;
    logic [CMD_BITS-1:0]    sel_payload;
    logic                   slot_free;
    logic                   grant;

    // Search begins just after the previous winner and wraps, so each index waits at most N-1 grants.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        cand_idx     = '0;
        for (int k = 1; k <= NUM_REQUESTORS; k++) begin
            cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQUESTORS);
            if (!winner_found && req_valid[cand_idx]) begin
                winner_found = 1'b1;
                winner_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_payload = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (IDX_W'(i) == winner_idx) begin
                sel_payload = req_payload[i*CMD_BITS +: CMD_BITS];
            end
        end
    end

    // Gating with rstn keeps req_ready low while reset is held, before any clock edge.
    assign slot_free = !cmd_valid_q || cmd_ready;
    assign grant     = rstn && enabled && slot_free && (credits_q != '0) && winner_found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner_idx] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_payload_d = cmd_payload_q;
        cmd_cu_id_d   = cmd_cu_id_q;
        credits_d     = credits_q;
        overflow_d    = overflow_q;

        if (grant) begin
            cmd_valid_d   = 1'b1;
            cmd_payload_d = sel_payload;
            cmd_cu_id_d   = CU_ID_RANGE'(winner_idx);
            last_grant_d  = winner_idx;
        end else if (cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        // A grant and a return in the same cycle cancel; an excess return is flagged, never counted.
        unique case ({grant, credit_return})
            2'b10: credits_d = credits_q - CREDIT_BITS'(1);
            2'b01: begin
                if (credits_q == CREDIT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    credits_d = credits_q + CREDIT_BITS'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            last_grant_q  <= LAST_IDX;
            cmd_valid_q   <= 1'b0;
            cmd_payload_q <= '0;
            cmd_cu_id_q   <= '0;
            credits_q     <= CREDIT_MAX;
            overflow_q    <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_payload_q <= cmd_payload_d;
            cmd_cu_id_q   <= cmd_cu_id_d;
            credits_q     <= credits_d;
            overflow_q    <= overflow_d;
        end
    end

    assign cmd_valid         = cmd_valid_q;
    assign cmd_payload       = cmd_payload_q;
    assign cmd_cu_id         = cmd_cu_id_q;
    assign credits_available = credits_q;
    assign credit_overflow   = overflow_q;

endmodule
